ltl_monitor_seq: RTL and testbench

- Sequencer for one LTL automaton instance in a monitor cluster.
- Takes an 8-bit trace-symbol stream (valid/ready with last), arms the automaton with a one-cycle reset at each trace start, and drives the automaton's run/symbols inputs.
- Captures non-zero report vectors, tagged with the symbol index, into a report FIFO for the cluster collector.

---
 rtl/ltl_monitor_pkg.sv | 23 ++
 rtl/ltl_report_fifo.sv | 71 +++++++
 rtl/ltl_monitor_seq.sv | 132 +++++++++++++
 tb/tb_ltl_monitor_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_monitor_pkg.sv
// Shared types and constants for the LTL monitor sequencer slice.
//   state_e   : sequencer FSM states
//   DEF_*     : default parameter values for the top and its FIFO
//   fifo_aw() : FIFO address width for a power-of-two depth
package ltl_monitor_pkg;

    localparam int unsigned DEF_N_REPORT   = 4;
    localparam int unsigned DEF_IDX_W      = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    function automatic int unsigned fifo_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous report FIFO with registered status flags.
//   clk, reset       : clock, synchronous active-high reset (flushes contents)
//   push_i, wdata_i  : write request and data (ignored when full)
//   pop_i, rdata_o   : read request and head-of-queue data (ignored when empty)
//   full_o, empty_o  : occupancy flags, derived from the registered count
//   free_o           : number of free entries
module ltl_report_fifo
    import ltl_monitor_pkg::*;
#(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned AW    = fifo_aw(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  free_o
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign free_o  = DEPTH_C - cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ltl_monitor_seq.sv
// Sequencer for one LTL automaton instance.
//   s_valid/s_ready/s_data/s_last : trace-symbol stream in
//   auto_reset/auto_run/auto_symbols : automaton drive (one-cycle reset per trace)
//   auto_report   : automaton report bits, valid one cycle after the symbol
//   r_valid/r_ready/r_data : report FIFO out, entry = {symbol index, report bits}
//   busy          : FSM not idle
//   trace_done    : one-cycle pulse at end of trace
//   report_cnt    : reports pushed this trace, saturating
module ltl_monitor_seq
    import ltl_monitor_pkg::*;
#(
    parameter int unsigned N_REPORT   = DEF_N_REPORT,
    parameter int unsigned IDX_W      = DEF_IDX_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [7:0]                s_data,
    input  logic                      s_last,
    output logic                      auto_reset,
    output logic                      auto_run,
    output logic [7:0]                auto_symbols,
    input  logic [N_REPORT-1:0]       auto_report,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic [IDX_W+N_REPORT-1:0] r_data,
    output logic                      busy,
    output logic                      trace_done,
    output logic [CNT_W-1:0]          report_cnt
);

    localparam int unsigned FIFO_AW = fifo_aw(FIFO_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0]    idx;
        logic [N_REPORT-1:0] bits;
    } report_entry_t;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cap_v_q;
    logic [IDX_W-1:0]   cap_idx_q;

    logic               accept;
    logic               space_ok;
    logic               push_req;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_free;
    report_entry_t      wr_entry;

    // Two free slots: one for the capture already in flight, one for this accept.
    assign space_ok = (fifo_free >= (FIFO_AW+1)'(2));

    assign s_ready      = !reset && (state_q == STREAM) && space_ok;
    assign accept       = s_valid && s_ready;
    assign auto_run     = accept;
    assign auto_symbols = s_data;
    assign auto_reset   = reset || (state_q == ARM);
    assign busy         = !reset && (state_q != IDLE);
    assign trace_done   = !reset && (state_q == DRAIN);
    assign report_cnt   = cnt_q;
    assign r_valid      = !fifo_empty;

    assign push_req      = cap_v_q && (|auto_report);
    assign fifo_push     = push_req && !fifo_full;
    assign wr_entry.idx  = cap_idx_q;
    assign wr_entry.bits = auto_report;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = (fifo_push && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            IDLE: begin
                if (s_valid) state_d = ARM;
            end
            ARM: begin
                idx_d = '0;
                cnt_d = '0;
                if (space_ok) state_d = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (s_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            cap_v_q   <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cap_v_q   <= accept;
            cap_idx_q <= idx_q;
        end
    end

    ltl_report_fifo #(
        .W     (IDX_W + N_REPORT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (wr_entry),
        .pop_i   (r_valid && r_ready),
        .rdata_o (r_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .free_o  (fifo_free)
    );

endmodule

// File: tb/tb_ltl_monitor_seq.sv
module tb_ltl_monitor_seq;
    import ltl_monitor_pkg::*;

    logic       clk;
    logic       reset;
    logic       s_valid, s_ready, s_last;
    logic [7:0] s_data;
    logic       auto_reset, auto_run;
    logic [7:0] auto_symbols;
    logic [3:0] auto_report;
    logic       r_valid, r_ready;
    logic [7:0] r_data;
    logic       busy, trace_done;
    logic [1:0] report_cnt;

    int total = 0;
    int bad   = 0;
    int stub_mode = 0;
    logic [3:0] stub_q = '0;
    logic [7:0] exp_q[$];

    ltl_monitor_seq #(
        .N_REPORT   (4),
        .IDX_W      (4),
        .FIFO_DEPTH (8),
        .CNT_W      (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .auto_reset   (auto_reset),
        .auto_run     (auto_run),
        .auto_symbols (auto_symbols),
        .auto_report  (auto_report),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_data       (r_data),
        .busy         (busy),
        .trace_done   (trace_done),
        .report_cnt   (report_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub automaton: registered report, one cycle after the symbol.
    function automatic logic [3:0] stub_rep(input int mode, input logic [7:0] sym);
        case (mode)
            0:       return (sym == 8'h80) ? 4'b0001 : 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b1000;
            default: return (sym < 8'h33) ? 4'b0010 : 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (auto_reset)    stub_q <= '0;
        else if (auto_run) stub_q <= stub_rep(stub_mode, auto_symbols);
        else               stub_q <= '0;
    end
    assign auto_report = stub_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(dut.push_req && dut.fifo_full))
        else $error("FAIL fifo_overflow: push while full");
    a_src_hold: assert property (@(posedge clk) disable iff (reset)
        (s_valid && !s_ready) |=> s_valid)
        else $error("FAIL src_hold: s_valid dropped before accept");
    a_first_sym: assert property (@(posedge clk) disable iff (reset)
        (dut.state_q == ARM && dut.state_d == STREAM) |=> s_valid)
        else $error("FAIL first_sym: no symbol in first STREAM cycle");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int val);
        total++;
        bad++;
        $display("FAIL %s: got %0d want completion", name, val);
    endtask

    // Drives one trace of n symbols (0x30+k, or 0xFF in mode 2) and drains reports.
    // r_ready stays low for the first 'hold' cycles; abort_at>=0 stops after that many accepts.
    task automatic run_trace(input int n, input int mode, input int hold, input int abort_at,
                             input string tag,
                             output int drop_k, output int busy_cyc, output int done_cnt,
                             output int first_cnt);
        int k;
        int cyc;
        bit fin;
        logic acc, busy_s;
        logic [7:0] sym, e;
        logic [3:0] bits;
        k = 0; cyc = 0; fin = 0;
        stub_mode = mode;
        drop_k = -1; busy_cyc = 0; done_cnt = 0; first_cnt = -1;
        while (!fin) begin
            @(negedge clk);
            sym     = (mode == 2) ? 8'hFF : 8'h30 + k[7:0];
            s_valid = (k < n);
            s_data  = sym;
            s_last  = (k == n - 1);
            r_ready = (cyc >= hold);
            #1;
            acc    = s_valid && s_ready;
            busy_s = busy;
            if (busy) busy_cyc++;
            if (trace_done) done_cnt++;
            if (s_valid && !s_ready && busy && k > 0 && drop_k < 0) drop_k = k;
            if (acc && k == 0) first_cnt = int'(report_cnt);
            if (acc) chk($sformatf("%s_sym%0d", tag, k), 32'(auto_symbols), 32'(sym));
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) fail_now($sformatf("%s_extra_entry", tag), int'(r_data));
                else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s_entry", tag), 32'(r_data), 32'(e));
                end
            end
            if (acc) begin
                bits = stub_rep(mode, sym);
                if (bits != 4'b0000) exp_q.push_back({k[3:0], bits});
            end
            @(posedge clk);
            if (acc) k++;
            cyc++;
            if (abort_at >= 0 && k == abort_at) fin = 1;
            else if (k == n && exp_q.size() == 0 && !busy_s) fin = 1;
            if (!fin && cyc > 400) begin
                fail_now($sformatf("%s_timeout", tag), cyc);
                fin = 1;
            end
        end
    endtask

    typedef struct packed {
        logic       rst, sv, sl;
        logic [7:0] sd;
        logic       rr;
        logic       e_rdy, e_ar, e_run, e_busy, e_done, e_rv;
        logic [7:0] e_rd;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[10];
    int drop_k, busy_cyc, done_cnt, first_cnt;

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; r_ready = 1'b1;

        // Known-index trace {10,80,20}: report bit0 for symbol 80 at idx 1.
        //               rst  sv   sl   sd     rr   rdy  ar   run  busy done rv   rd     cnt
        tbl[0] = '{1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,2'd0};
        tbl[1] = '{1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,2'd0};
        tbl[2] = '{1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,2'd0};
        tbl[3] = '{1'b0,1'b1,1'b0,8'h10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,2'd0};
        tbl[4] = '{1'b0,1'b1,1'b0,8'h10,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,2'd0};
        tbl[5] = '{1'b0,1'b1,1'b0,8'h10,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,8'h00,2'd0};
        tbl[6] = '{1'b0,1'b1,1'b0,8'h80,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,8'h00,2'd0};
        tbl[7] = '{1'b0,1'b1,1'b1,8'h20,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,8'h00,2'd0};
        tbl[8] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,8'h11,2'd1};
        tbl[9] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,2'd1};

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            reset = tbl[i].rst; s_valid = tbl[i].sv; s_last = tbl[i].sl;
            s_data = tbl[i].sd; r_ready = tbl[i].rr;
            #1;
            chk($sformatf("v%0d_s_ready", i),    32'(s_ready),    32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_auto_reset", i), 32'(auto_reset), 32'(tbl[i].e_ar));
            chk($sformatf("v%0d_auto_run", i),   32'(auto_run),   32'(tbl[i].e_run));
            chk($sformatf("v%0d_busy", i),       32'(busy),       32'(tbl[i].e_busy));
            chk($sformatf("v%0d_trace_done", i), 32'(trace_done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d_r_valid", i),    32'(r_valid),    32'(tbl[i].e_rv));
            chk($sformatf("v%0d_report_cnt", i), 32'(report_cnt), 32'(tbl[i].e_cnt));
            if (tbl[i].e_rv)  chk($sformatf("v%0d_r_data", i), 32'(r_data), 32'(tbl[i].e_rd));
            if (tbl[i].e_run) chk($sformatf("v%0d_auto_symbols", i), 32'(auto_symbols), 32'(tbl[i].sd));
        end

        // Single-symbol trace 0xFF with report 4'b1000.
        run_trace(1, 2, 0, -1, "single", drop_k, busy_cyc, done_cnt, first_cnt);
        chk("single_busy_cycles", 32'(busy_cyc), 32'd3);
        chk("single_done_pulses", 32'(done_cnt), 32'd1);
        chk("single_cnt_cleared", 32'(first_cnt), 32'd0);

        // Backpressure: 10 reporting symbols, r_ready low for 20 cycles.
        run_trace(10, 1, 20, -1, "bp", drop_k, busy_cyc, done_cnt, first_cnt);
        chk("bp_drop_after_accepts", 32'(drop_k), 32'd8);
        chk("bp_done_pulses", 32'(done_cnt), 32'd1);
        @(negedge clk); #1;
        chk("bp_fifo_empty_after", 32'(r_valid), 32'd0);

        // Index wrap with IDX_W=4: 20 reporting symbols give idx 0..15, 0..3.
        run_trace(20, 1, 0, -1, "wrap", drop_k, busy_cyc, done_cnt, first_cnt);
        chk("wrap_no_stall", 32'(drop_k), 32'hFFFF_FFFF);
        chk("wrap_done_pulses", 32'(done_cnt), 32'd1);

        // Saturation with CNT_W=2, then the next ARM clears the counter.
        run_trace(6, 1, 0, -1, "sat", drop_k, busy_cyc, done_cnt, first_cnt);
        @(negedge clk); #1;
        chk("sat_cnt_held", 32'(report_cnt), 32'd3);
        run_trace(2, 0, 0, -1, "sat2", drop_k, busy_cyc, done_cnt, first_cnt);
        chk("sat2_cnt_cleared", 32'(first_cnt), 32'd0);
        chk("sat2_cnt_end", 32'(report_cnt), 32'd0);

        // Mid-trace reset after 5 accepts with 3 entries queued.
        run_trace(10, 3, 1000, 5, "mid", drop_k, busy_cyc, done_cnt, first_cnt);
        chk("mid_queued", 32'(exp_q.size()), 32'd3);
        chk("mid_no_done_before", 32'(done_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; r_ready = 1'b0;
        #1;
        chk("mid_rst_auto_reset", 32'(auto_reset), 32'd1);
        chk("mid_rst_done", 32'(trace_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_r_valid", 32'(r_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(trace_done), 32'd0);
        chk("mid_cnt", 32'(report_cnt), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk($sformatf("mid_flushed%0d", i), 32'(r_valid), 32'd0);
            chk($sformatf("mid_nodone%0d", i), 32'(trace_done), 32'd0);
        end
        run_trace(3, 1, 0, -1, "post", drop_k, busy_cyc, done_cnt, first_cnt);
        chk("post_done_pulses", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
